// File: rtl/doc_receiver.sv
// doc_receiver: oversampling UART receiver plus document framing FSM.
// Accepts ACK, 300 printable characters (15 rows x 20 columns, row-major)
// and EOF, and drives the document memory write port with character codes.
module doc_receiver #(
    parameter int          CLKS_PER_BIT = 434,
    parameter logic [7:0]  SIGACK       = 8'hCC,
    parameter logic [7:0]  SIGEOF       = 8'hDD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RsRx,
    output logic       write_en,
    output logic [9:0] write_addr,
    output logic [7:0] write_data,
    output logic       busy,
    output logic       done,
    output logic       error
);

    localparam int CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
    typedef enum logic [1:0] {D_IDLE, D_DATA, D_EOF} doc_state_t;

    // ---------------- synchronizer ----------------
    logic r_rx_meta;
    logic r_rx_s;

    // Two-flop synchronizer; idles high so reset does not look like a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= RsRx;
            r_rx_s    <= r_rx_meta;
        end
    end

    // ---------------- UART receiver ----------------
    rx_state_t        r_rx_state, w_rx_state_next;
    logic [CNT_W-1:0] r_cnt, w_cnt_next;
    logic [2:0]       r_bit_cnt, w_bit_cnt_next;
    logic [7:0]       r_shift, w_shift_next;
    logic [7:0]       r_byte, w_byte_next;
    logic             r_byte_valid, w_byte_valid_next;
    logic             r_frame_err, w_frame_err_next;

    // Receiver state, bit timing counter and the registered byte/strobes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rx_state   <= R_IDLE;
            r_cnt        <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_byte       <= '0;
            r_byte_valid <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_state_next;
            r_cnt        <= w_cnt_next;
            r_bit_cnt    <= w_bit_cnt_next;
            r_shift      <= w_shift_next;
            r_byte       <= w_byte_next;
            r_byte_valid <= w_byte_valid_next;
            r_frame_err  <= w_frame_err_next;
        end
    end

    // Receiver next state: half-bit to start centre, then full bits per sample.
    always_comb begin
        w_rx_state_next   = r_rx_state;
        w_cnt_next        = r_cnt + 1'b1;
        w_bit_cnt_next    = r_bit_cnt;
        w_shift_next      = r_shift;
        w_byte_next       = r_byte;
        w_byte_valid_next = 1'b0;
        w_frame_err_next  = 1'b0;
        case (r_rx_state)
            R_IDLE: begin
                w_cnt_next     = '0;
                w_bit_cnt_next = '0;
                if (!r_rx_s) w_rx_state_next = R_START;
            end
            R_START: begin
                if (r_cnt == HALF_M1) begin
                    w_cnt_next      = '0;
                    // A line that is high again at mid start bit was a glitch.
                    w_rx_state_next = r_rx_s ? R_IDLE : R_DATA;
                end
            end
            R_DATA: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_next     = '0;
                    w_shift_next   = {r_rx_s, r_shift[7:1]};
                    w_bit_cnt_next = r_bit_cnt + 1'b1;
                    if (r_bit_cnt == 3'd7) w_rx_state_next = R_STOP;
                end
            end
            R_STOP: begin
                if (r_cnt == FULL_M1) begin
                    w_cnt_next      = '0;
                    w_rx_state_next = R_IDLE;
                    if (r_rx_s) begin
                        w_byte_valid_next = 1'b1;
                        w_byte_next       = r_shift;
                    end else begin
                        w_frame_err_next  = 1'b1;
                    end
                end
            end
            default: w_rx_state_next = R_IDLE;
        endcase
    end

    // ---------------- document framing ----------------
    doc_state_t r_doc_state, w_doc_state_next;
    logic [4:0] r_x, w_x_next;
    logic [3:0] r_y, w_y_next;
    logic       r_write_en, w_write_en_next;
    logic [9:0] r_write_addr, w_write_addr_next;
    logic [7:0] r_write_data, w_write_data_next;
    logic       r_done, w_done_next;
    logic       r_error, w_error_next;
    logic       w_printable;

    assign w_printable = (r_byte >= 8'h20) && (r_byte <= 8'h7F);

    // Document state, cursor and registered memory-port / status outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_doc_state  <= D_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_write_en   <= 1'b0;
            r_write_addr <= '0;
            r_write_data <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_doc_state  <= w_doc_state_next;
            r_x          <= w_x_next;
            r_y          <= w_y_next;
            r_write_en   <= w_write_en_next;
            r_write_addr <= w_write_addr_next;
            r_write_data <= w_write_data_next;
            r_done       <= w_done_next;
            r_error      <= w_error_next;
        end
    end

    // Document next state: write printable bytes, abort on anything else.
    always_comb begin
        w_doc_state_next  = r_doc_state;
        w_x_next          = r_x;
        w_y_next          = r_y;
        w_write_en_next   = 1'b0;
        w_write_addr_next = r_write_addr;
        w_write_data_next = r_write_data;
        w_done_next       = 1'b0;
        w_error_next      = 1'b0;
        case (r_doc_state)
            D_IDLE: begin
                w_x_next = '0;
                w_y_next = '0;
                if (r_byte_valid && (r_byte == SIGACK)) w_doc_state_next = D_DATA;
            end
            D_DATA: begin
                if (r_frame_err || (r_byte_valid && !w_printable)) begin
                    w_error_next     = 1'b1;
                    w_doc_state_next = D_IDLE;
                end else if (r_byte_valid) begin
                    w_write_en_next   = 1'b1;
                    w_write_data_next = r_byte - 8'h20;
                    w_write_addr_next = {1'b0, r_y, r_x};
                    if (r_x == 5'd19) begin
                        w_x_next = '0;
                        if (r_y == 4'd14) begin
                            w_y_next         = '0;
                            w_doc_state_next = D_EOF;
                        end else begin
                            w_y_next = r_y + 1'b1;
                        end
                    end else begin
                        w_x_next = r_x + 1'b1;
                    end
                end
            end
            D_EOF: begin
                if (r_frame_err || (r_byte_valid && (r_byte != SIGEOF))) begin
                    w_error_next     = 1'b1;
                    w_doc_state_next = D_IDLE;
                end else if (r_byte_valid) begin
                    w_done_next      = 1'b1;
                    w_doc_state_next = D_IDLE;
                end
            end
            default: w_doc_state_next = D_IDLE;
        endcase
    end

    assign write_en   = r_write_en;
    assign write_addr = r_write_addr;
    assign write_data = r_write_data;
    assign busy       = (r_doc_state != D_IDLE);
    assign done       = r_done;
    assign error      = r_error;

endmodule
